// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one synchronous-read data RAM between the CPU load/store path and
//   a read-only peripheral port. The CPU has fixed priority, and a starvation
//   counter bounds how long the peripheral can wait. The RAM returns read data
//   one cycle after the address, so every read spends one extra cycle in a
//   data-return state. The arbiter only drives a new address from IDLE.
//
// Ports
//   clk, rst          single clock; synchronous active-high reset
//   cpu_req/we/addr/wdata   CPU access request (we=1 store, we=0 load)
//   cpu_rdata         load data, valid in the cycle cpu_stall falls
//   cpu_stall         freezes the core's PC and pipeline registers
//   per_req/addr      peripheral read request, held until per_rvalid
//   per_gnt           one-cycle pulse: peripheral address accepted
//   per_rvalid/rdata  one-cycle pulse with peripheral read data
//   mem_addr/we/wdata RAM command
//   mem_rdata         RAM read data, one cycle after mem_addr
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4     // legal range 1..255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,

    input  logic              per_req,
    input  logic [ADDR_W-1:0] per_addr,
    output logic              per_gnt,
    output logic              per_rvalid,
    output logic [DATA_W-1:0] per_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        PER_RD = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        starve_cnt;
    logic              per_win;
    logic              cpu_win;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] per_rdata_q;

    // Arbitration. The peripheral only overrides an active CPU request once
    // it has been pending for STARVE_LIMIT cycles.
    always_comb begin
        per_win = 1'b0;
        cpu_win = 1'b0;
        if (state == IDLE) begin
            per_win = per_req && (!cpu_req || (starve_cnt == LIMIT));
            cpu_win = cpu_req && !per_win;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: stores complete in the issue cycle, reads need a return cycle.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (per_win)                 state_nxt = PER_RD;
                else if (cpu_win && !cpu_we) state_nxt = CPU_RD;
                else                         state_nxt = IDLE;
            end
            CPU_RD:  state_nxt = IDLE;
            PER_RD:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs. Every pulse, the stall and the write enable are forced low
    // while rst is high, so a reset in a return cycle drops that transfer.
    always_comb begin
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        mem_we     = 1'b0;
        cpu_stall  = 1'b0;
        per_gnt    = 1'b0;
        per_rvalid = 1'b0;
        cpu_rdata  = cpu_rdata_q;
        per_rdata  = per_rdata_q;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (per_win) begin
                        mem_addr  = per_addr;
                        per_gnt   = 1'b1;
                        cpu_stall = cpu_req;
                    end else if (cpu_win) begin
                        mem_we    = cpu_we;
                        cpu_stall = !cpu_we;
                    end
                end
                CPU_RD: begin
                    // Load data bypasses the holding register in its valid cycle.
                    cpu_rdata = mem_rdata;
                end
                PER_RD: begin
                    per_rdata  = mem_rdata;
                    per_rvalid = 1'b1;
                    cpu_stall  = cpu_req;
                end
                default: ;
            endcase
        end
    end

    // Starvation counter: counts pending, ungranted peripheral cycles,
    // saturating at the limit; any grant or dropped request clears it.
    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (!per_req || per_gnt)
            starve_cnt <= '0;
        else if (starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 8'd1;
    end

    // Read data holding registers keep the last returned value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata_q <= '0;
            per_rdata_q <= '0;
        end else begin
            if (state == CPU_RD) cpu_rdata_q <= mem_rdata;
            if (state == PER_RD) per_rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural RAM, a transaction-level reference
// model with its own shadow memory, directed scenarios and a random run.
module tb_dmem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        per_req;
    logic [31:0] per_addr;
    logic        per_gnt, per_rvalid;
    logic [31:0] per_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .per_req(per_req), .per_addr(per_addr), .per_gnt(per_gnt),
        .per_rvalid(per_rvalid), .per_rdata(per_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment RAM: one-cycle synchronous read, write on mem_we.
    logic [31:0] ram [64];
    always @(posedge clk) begin
        logic [31:0] rd;
        rd = ram[mem_addr[5:0]];
        if (mem_we) ram[mem_addr[5:0]] = mem_wdata;
        mem_rdata <= rd;
    end

    // Reference model: shadow memory plus "what is owed to whom next cycle".
    logic [31:0] ref_mem [64];
    bit          owe_cpu, owe_per;
    logic [31:0] owe_data;
    logic [31:0] hold_cpu, hold_per;
    int          waited;

    // Last sampled DUT outputs, for directed checks.
    logic        o_gnt, o_rv, o_stall, o_we;
    logic [31:0] o_crd, o_prd, o_maddr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_cycle();
        logic        e_gnt, e_rv, e_we, e_stall;
        logic [31:0] e_crd, e_prd;
        e_gnt = 0; e_rv = 0; e_we = 0; e_stall = 0;
        e_crd = hold_cpu; e_prd = hold_per;
        if (rst) begin
            owe_cpu = 0; owe_per = 0;
        end else if (owe_cpu) begin
            e_crd = owe_data; hold_cpu = owe_data; owe_cpu = 0;
        end else if (owe_per) begin
            e_rv = 1; e_prd = owe_data; hold_per = owe_data; owe_per = 0;
            e_stall = cpu_req;
        end else if (per_req && (!cpu_req || waited >= LIMIT)) begin
            e_gnt = 1; e_stall = cpu_req;
            owe_per = 1; owe_data = ref_mem[per_addr[5:0]];
            chk("per_mem_addr", mem_addr, per_addr);
        end else if (cpu_req) begin
            chk("cpu_mem_addr", mem_addr, cpu_addr);
            if (cpu_we) begin
                e_we = 1;
                ref_mem[cpu_addr[5:0]] = cpu_wdata;
                chk("mem_wdata", mem_wdata, cpu_wdata);
            end else begin
                e_stall = 1;
                owe_cpu = 1; owe_data = ref_mem[cpu_addr[5:0]];
            end
        end
        chk("per_gnt", {31'd0, per_gnt}, {31'd0, e_gnt});
        chk("per_rvalid", {31'd0, per_rvalid}, {31'd0, e_rv});
        chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
        chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, e_stall});
        chk("cpu_rdata", cpu_rdata, e_crd);
        chk("per_rdata", per_rdata, e_prd);
        if (rst) begin
            waited = 0; hold_cpu = '0; hold_per = '0;
        end else if (per_req && !e_gnt) begin
            if (waited < LIMIT) waited++;
        end else begin
            waited = 0;
        end
    endtask

    task automatic step(input logic r, input logic rq, input logic we,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic prq, input logic [31:0] pa);
        @(negedge clk);
        rst = r; cpu_req = rq; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        per_req = prq; per_addr = pa;
        #2;
        o_gnt = per_gnt; o_rv = per_rvalid; o_stall = cpu_stall; o_we = mem_we;
        o_crd = cpu_rdata; o_prd = per_rdata; o_maddr = mem_addr;
        model_cycle();
    endtask

    initial begin
        bit          p_act, p_gnt;
        logic [31:0] p_addr;
        for (int i = 0; i < 64; i++) begin
            ram[i]     = 32'hA500_0000 + 32'(i * 7);
            ref_mem[i] = 32'hA500_0000 + 32'(i * 7);
        end
        ram[6'h20] = 32'h1234; ref_mem[6'h20] = 32'h1234;
        owe_cpu = 0; owe_per = 0; owe_data = '0;
        hold_cpu = '0; hold_per = '0; waited = 0;
        rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        per_req = 0; per_addr = '0;

        // Reset with both requesters active; CPU wins the first IDLE after.
        step(1, 1, 1, 32'h04, 32'h1111, 1, 32'h08);
        step(1, 1, 1, 32'h04, 32'h1111, 1, 32'h08);
        step(0, 1, 1, 32'h04, 32'h1111, 1, 32'h08);
        chk("post_reset_cpu_first", {31'd0, o_we}, 32'd1);
        step(0, 0, 0, 32'h0, 32'h0, 1, 32'h08);   // peripheral granted
        step(0, 0, 0, 32'h0, 32'h0, 1, 32'h08);   // its data returns
        step(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);

        // Store then load, no peripheral.
        step(0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 32'h0);
        chk("store_no_stall", {31'd0, o_stall}, 32'd0);
        step(0, 1, 0, 32'h10, 32'h0, 0, 32'h0);
        chk("load_issue_stall", {31'd0, o_stall}, 32'd1);
        step(0, 1, 0, 32'h10, 32'h0, 0, 32'h0);
        chk("load_data", o_crd, 32'hDEADBEEF);
        step(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);

        // Peripheral alone.
        step(0, 0, 0, 32'h0, 32'h0, 1, 32'h20);
        chk("per_alone_gnt", {31'd0, o_gnt}, 32'd1);
        step(0, 0, 0, 32'h0, 32'h0, 1, 32'h20);
        chk("per_alone_data", o_prd, 32'h1234);
        step(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);

        // Starvation: continuous CPU stores, peripheral held.
        for (int c = 1; c <= 7; c++) begin
            step(0, 1, 1, 32'h30 + 32'(c), 32'h5000 + 32'(c), (c <= 6), 32'h18);
            if (c == 5) chk("starve_gnt_5th", {31'd0, o_gnt}, 32'd1);
            if (c == 6) chk("starve_stall_rd", {31'd0, o_stall}, 32'd1);
            if (c == 7) chk("starve_cpu_resume", {31'd0, o_we}, 32'd1);
        end

        // Collision with a load at a fresh counter: CPU first, then peripheral.
        step(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        step(0, 1, 0, 32'h31, 32'h0, 1, 32'h20);
        chk("collide_cpu_first", {31'd0, o_gnt}, 32'd0);
        step(0, 1, 0, 32'h31, 32'h0, 1, 32'h20);
        step(0, 0, 0, 32'h0, 32'h0, 1, 32'h20);
        chk("collide_per_next", {31'd0, o_gnt}, 32'd1);
        step(0, 0, 0, 32'h0, 32'h0, 1, 32'h20);
        step(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);

        // Reset in the load return cycle.
        step(0, 1, 0, 32'h10, 32'h0, 0, 32'h0);
        step(0, 1, 0, 32'h10, 32'h0, 0, 32'h0);
        step(0, 1, 0, 32'h20, 32'h0, 0, 32'h0);
        step(1, 1, 0, 32'h20, 32'h0, 0, 32'h0);
        chk("rst_mid_load_hold", o_crd, 32'hDEADBEEF);
        step(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        chk("rst_mid_load_clear", o_crd, 32'h0);

        // Random traffic with a protocol-respecting peripheral.
        p_act = 0; p_gnt = 0; p_addr = '0;
        for (int n = 0; n < 400; n++) begin
            if (!p_act && ($urandom % 3 == 0)) begin
                p_act = 1; p_gnt = 0; p_addr = 32'($urandom_range(0, 63));
            end else if (p_act && !p_gnt && ($urandom % 16 == 0)) begin
                p_act = 0;
            end
            step(($urandom % 97) == 0, ($urandom % 4) != 0, $urandom % 2,
                 32'($urandom_range(0, 63)), $urandom, p_act, p_addr);
            if (rst) begin
                p_act = 0; p_gnt = 0;
            end else begin
                if (o_gnt) p_gnt = 1;
                if (o_rv)  begin p_act = 0; p_gnt = 0; end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
